// File: rtl/nios_system_switch_input.sv
// ---------------------------------------------------------------------------
// nios_system_switch_input
//
// Avalon-MM slave input port for the board slide switches. Each raw switch
// passes through a two-flop synchronizer and then a per-bit debounce
// filter. Rising edges of the filtered value are latched into a
// write-1-to-clear edge-capture register, and a maskable level interrupt
// goes to the Nios II CPU.
//
// Optional build macro:
//   SWITCHES_ANY_EDGE_CAPTURE_EN - when defined, edgecapture also latches
//                                  falling edges (any transition of the
//                                  filtered value). Undefined: rising only.
//
// Parameters:
//   WIDTH            number of switch inputs (1..32)
//   DEBOUNCE_CYCLES  consecutive cycles an input must disagree with the
//                    filtered value before the filter follows (>=1)
//   CNT_W            debounce counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   reset_n     active-low reset, synchronous to clk
//   address     register word address (0 data, 1 reserved, 2 irqmask,
//               3 edgecapture)
//   chipselect  Avalon slave select
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     raw asynchronous switch inputs
//   readdata    read data, combinational (zero wait states, latency 0)
//   irq         level interrupt, |(edgecapture & irqmask)
// ---------------------------------------------------------------------------
module nios_system_switch_input #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Counter value on which the filter accepts the new input level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] capture_set;
    logic [WIDTH-1:0] irqmask_reg;
    logic [WIDTH-1:0] irqmask_next;
    logic [WIDTH-1:0] edgecapture_reg;
    logic [WIDTH-1:0] edgecapture_next;
    logic [WIDTH-1:0] clear_bits;
    logic             wr_en;

    // Only the low WIDTH bits of writedata are architecturally meaningful.
    logic             unused_writedata;
    assign unused_writedata = &{1'b0, writedata};

    // ------------------------------------------------------------------
    // Two-flop synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= in_port;
            sync2_reg <= sync1_reg;
        end
    end

    // ------------------------------------------------------------------
    // Per-bit debounce filter and edge detection
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             stable_reg;
            logic             stable_next;
            logic             differ;
            logic             expire;

            always_comb begin
                differ      = (sync2_reg[gi] != stable_reg);
                // The filter flips only after DEBOUNCE_CYCLES consecutive
                // disagreeing samples; any agreeing sample restarts the count.
                expire      = differ && (cnt_reg == CNT_LAST);
                cnt_next    = '0;
                stable_next = stable_reg;
                if (expire) begin
                    stable_next = sync2_reg[gi];
                end else if (differ) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_reg    <= '0;
                    stable_reg <= 1'b0;
                end else begin
                    cnt_reg    <= cnt_next;
                    stable_reg <= stable_next;
                end
            end

            assign stable[gi] = stable_reg;

            // The capture bit sets on the same edge the filtered value moves.
`ifdef SWITCHES_ANY_EDGE_CAPTURE_EN
            assign capture_set[gi] = expire;
`else
            assign capture_set[gi] = expire && sync2_reg[gi];
`endif
        end
    endgenerate

    // ------------------------------------------------------------------
    // Register writes
    // ------------------------------------------------------------------
    assign wr_en = chipselect && !write_n;

    always_comb begin
        irqmask_next = irqmask_reg;
        if (wr_en && (address == 2'd2)) begin
            irqmask_next = writedata[WIDTH-1:0];
        end
        clear_bits = '0;
        if (wr_en && (address == 2'd3)) begin
            clear_bits = writedata[WIDTH-1:0];
        end
        // Set is OR-ed in after the clear so a simultaneous capture is kept.
        edgecapture_next = (edgecapture_reg & ~clear_bits) | capture_set;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irqmask_reg     <= '0;
            edgecapture_reg <= '0;
        end else begin
            irqmask_reg     <= irqmask_next;
            edgecapture_reg <= edgecapture_next;
        end
    end

    // ------------------------------------------------------------------
    // Read decode (independent of chipselect / write_n) and interrupt
    // ------------------------------------------------------------------
    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = stable;
            2'd2:    readdata[WIDTH-1:0] = irqmask_reg;
            2'd3:    readdata[WIDTH-1:0] = edgecapture_reg;
            default: readdata = '0;
        endcase
    end

    assign irq = |(edgecapture_reg & irqmask_reg);

endmodule
